demux_1x16_tdm: RTL and testbench

//  Registered 1-to-16 time-division demultiplexer, the receive-side counterpart of mux_16x1.

---
 rtl/demux_1x16_tdm.sv | 91 +++++++++
 tb/tb_demux_1x16_tdm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x16_tdm.sv
// Registered 1-to-16 time-division demultiplexer.
// Receives a serial word stream and scatters it onto 16 held channel registers.
// The slot comes from a frame-aligned counter (auto mode) or from s (manual mode).
module demux_1x16_tdm #(
  parameter int unsigned W     = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_start,
  input  logic              auto_mode,
  input  logic [3:0]        s,
  output logic [16*W-1:0]   ch_data,
  output logic [15:0]       ch_strobe,
  output logic              frame_done,
  output logic              sync_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [3:0]        slot
);

  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  logic [15:0][W-1:0] ch_q, ch_d;
  logic [15:0]        strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         slot_q, slot_d;
  logic [3:0]         tgt;

  // Target slot: frame_start realigns to 0 in auto mode; manual mode uses s directly.
  always_comb begin
    tgt = s;
    if (auto_mode) begin
      tgt = frame_start ? 4'd0 : slot_q;
    end
  end

  // Next-state: write the accepted word, pulse strobes, advance/realign the slot pointer.
  always_comb begin
    ch_d     = ch_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    if (din_valid) begin
      ch_d[tgt] = din;
      strobe_d  = 16'd1 << tgt;
      if (auto_mode) begin
        slot_d = tgt + 4'd1;  // wraps 15 -> 0
        done_d = (tgt == 4'd15);
        if (frame_start && (slot_q != 4'd0)) begin
          err_d = 1'b1;
          if (cnt_q != ErrMax) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous reset; reset discards any in-flight frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      slot_q   <= '0;
    end else begin
      ch_q     <= ch_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
    end
  end

  assign ch_data    = ch_q;
  assign ch_strobe  = strobe_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
  assign err_cnt    = cnt_q;
  assign slot       = slot_q;

endmodule

// File: tb/tb_demux_1x16_tdm.sv
// Directed testbench for demux_1x16_tdm: a default-width instance plus an ERR_W=2
// instance sharing the same stimulus for the saturation scenario.
module tb_demux_1x16_tdm;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_start = 1'b0;
  logic           auto_mode = 1'b1;
  logic [3:0]     s = '0;

  logic [16*W-1:0] ch_data;
  logic [15:0]     ch_strobe;
  logic            frame_done;
  logic            sync_err;
  logic [7:0]      err_cnt;
  logic [3:0]      slot;

  logic [16*W-1:0] ch_data2;
  logic [15:0]     ch_strobe2;
  logic            frame_done2;
  logic            sync_err2;
  logic [1:0]      err_cnt2;
  logic [3:0]      slot2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1x16_tdm #(.W(W), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .auto_mode(auto_mode), .s(s), .ch_data(ch_data), .ch_strobe(ch_strobe),
    .frame_done(frame_done), .sync_err(sync_err), .err_cnt(err_cnt), .slot(slot)
  );

  demux_1x16_tdm #(.W(W), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .auto_mode(auto_mode), .s(s), .ch_data(ch_data2), .ch_strobe(ch_strobe2),
    .frame_done(frame_done2), .sync_err(sync_err2), .err_cnt(err_cnt2), .slot(slot2)
  );

  // One clock cycle with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic v, input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ch_data !== '0) begin errors++;
      $display("FAIL reset_ch_data got %h exp 0", ch_data); end
    checks++; if (ch_strobe !== 16'h0000) begin errors++;
      $display("FAIL reset_strobe got %h exp 0000", ch_strobe); end
    checks++; if (frame_done !== 1'b0 || sync_err !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got done=%b err=%b exp 0 0", frame_done, sync_err); end
    checks++; if (err_cnt !== 8'd0 || slot !== 4'd0) begin errors++;
      $display("FAIL reset_cnt_slot got cnt=%0d slot=%0d exp 0 0", err_cnt, slot); end
  endtask

  task automatic test_auto();
    logic [16*W-1:0] exp_data;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, (k == 0), 8'h10 + 8'(k));
      exp_data[k*W +: W] = 8'h10 + 8'(k);
      checks++; if (ch_strobe !== (16'd1 << k)) begin errors++;
        $display("FAIL auto_strobe[%0d] got %h exp %h", k, ch_strobe, 16'd1 << k); end
      checks++; if (frame_done !== (k == 15)) begin errors++;
        $display("FAIL auto_done[%0d] got %b exp %b", k, frame_done, (k == 15)); end
      checks++; if (slot !== 4'((k + 1) % 16)) begin errors++;
        $display("FAIL auto_slot[%0d] got %0d exp %0d", k, slot, (k + 1) % 16); end
      checks++; if (sync_err !== 1'b0) begin errors++;
        $display("FAIL auto_no_err[%0d] got %b exp 0", k, sync_err); end
    end
    checks++; if (ch_data !== exp_data) begin errors++;
      $display("FAIL auto_ch_data got %h exp %h", ch_data, exp_data); end
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if (frame_done !== 1'b0 || ch_strobe !== 16'h0) begin errors++;
      $display("FAIL auto_done_once got done=%b strobe=%h exp 0 0", frame_done, ch_strobe); end
  endtask

  task automatic test_gaps();
    logic [16*W-1:0] exp_data;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, (k == 0), 8'h10 + 8'(k));
      exp_data[k*W +: W] = 8'h10 + 8'(k);
      checks++; if (ch_strobe !== (16'd1 << k)) begin errors++;
        $display("FAIL gap_strobe[%0d] got %h exp %h", k, ch_strobe, 16'd1 << k); end
      cycle(1'b0, 1'b0, 8'hEE);
      checks++; if (ch_strobe !== 16'h0 || frame_done !== 1'b0) begin errors++;
        $display("FAIL gap_idle[%0d] got strobe=%h done=%b exp 0 0", k, ch_strobe, frame_done); end
      checks++; if (slot !== 4'((k + 1) % 16)) begin errors++;
        $display("FAIL gap_slot_hold[%0d] got %0d exp %0d", k, slot, (k + 1) % 16); end
    end
    checks++; if (ch_data !== exp_data) begin errors++;
      $display("FAIL gap_ch_data got %h exp %h", ch_data, exp_data); end
  endtask

  task automatic test_misalign();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, (k == 0), 8'h30 + 8'(k));
    cycle(1'b1, 1'b1, 8'hAA);
    checks++; if (sync_err !== 1'b1 || err_cnt !== 8'd1) begin errors++;
      $display("FAIL mis_err got err=%b cnt=%0d exp 1 1", sync_err, err_cnt); end
    checks++; if (ch_data[7:0] !== 8'hAA || ch_strobe !== 16'h0001) begin errors++;
      $display("FAIL mis_ch0 got %h strobe=%h exp aa 0001", ch_data[7:0], ch_strobe); end
    checks++; if (slot !== 4'd1) begin errors++;
      $display("FAIL mis_slot got %0d exp 1", slot); end
    checks++; if (ch_data[39:8] !== 32'h34333231) begin errors++;
      $display("FAIL mis_keep got %h exp 34333231", ch_data[39:8]); end
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if (sync_err !== 1'b0 || err_cnt !== 8'd1) begin errors++;
      $display("FAIL mis_pulse got err=%b cnt=%0d exp 0 1", sync_err, err_cnt); end
  endtask

  task automatic test_manual();
    auto_mode = 1'b0;
    s = 4'd9;
    cycle(1'b1, 1'b0, 8'h5C);
    checks++; if (ch_data[9*W +: W] !== 8'h5C || ch_strobe !== 16'h0200) begin errors++;
      $display("FAIL man_s9 got %h strobe=%h exp 5c 0200", ch_data[9*W +: W], ch_strobe); end
    checks++; if (slot !== 4'd1 || frame_done !== 1'b0) begin errors++;
      $display("FAIL man_slot got slot=%0d done=%b exp 1 0", slot, frame_done); end
    s = 4'd15;
    cycle(1'b1, 1'b1, 8'h5D);
    checks++; if (frame_done !== 1'b0 || ch_strobe !== 16'h8000 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL man_s15 got done=%b strobe=%h err=%b exp 0 8000 0",
               frame_done, ch_strobe, sync_err); end
    checks++; if (ch_data[15*W +: W] !== 8'h5D || ch_data[7:0] !== 8'hAA) begin errors++;
      $display("FAIL man_ch15 got %h ch0=%h exp 5d aa", ch_data[15*W +: W], ch_data[7:0]); end
    auto_mode = 1'b1;
    cycle(1'b1, 1'b0, 8'h61);
    checks++; if (ch_strobe !== 16'h0002 || slot !== 4'd2) begin errors++;
      $display("FAIL man_resume got strobe=%h slot=%0d exp 0002 2", ch_strobe, slot); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    do_reset();
    cycle(1'b1, 1'b1, 8'h40);
    checks++; if (sync_err2 !== 1'b0 || err_cnt2 !== 2'd0) begin errors++;
      $display("FAIL sat_aligned got err=%b cnt=%0d exp 0 0", sync_err2, err_cnt2); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 8'h41 + 8'(k));
      checks++; if (err_cnt2 !== exp_sat[k] || sync_err2 !== 1'b1) begin errors++;
        $display("FAIL sat_cnt[%0d] got cnt=%0d err=%b exp %0d 1",
                 k, err_cnt2, sync_err2, exp_sat[k]); end
    end
    checks++; if (err_cnt !== 8'd5) begin errors++;
      $display("FAIL sat_wide_cnt got %0d exp 5", err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 7; k++) cycle(1'b1, (k == 0), 8'h50 + 8'(k));
    checks++; if (slot !== 4'd7) begin errors++;
      $display("FAIL rmid_pre_slot got %0d exp 7", slot); end
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b1; din = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0; din_valid = 1'b0;
    checks++; if (ch_data !== '0 || ch_strobe !== 16'h0 || slot !== 4'd0) begin errors++;
      $display("FAIL rmid_clear got data=%h strobe=%h slot=%0d exp 0 0 0",
               ch_data, ch_strobe, slot); end
    cycle(1'b1, 1'b0, 8'h88);
    checks++; if (ch_data[7:0] !== 8'h88 || ch_strobe !== 16'h0001 || slot !== 4'd1) begin
      errors++;
      $display("FAIL rmid_next got ch0=%h strobe=%h slot=%0d exp 88 0001 1",
               ch_data[7:0], ch_strobe, slot); end
    checks++; if (sync_err !== 1'b0) begin errors++;
      $display("FAIL rmid_no_err got %b exp 0", sync_err); end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_gaps();
    test_misalign();
    test_manual();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
